// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the serial pattern detector
package seq_det_pkg;
  localparam logic [3:0] DEF_PATTERN_1101 = 4'b1101;
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with clear taking priority over increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;
  // next count: clear wins, otherwise increment unless already saturated
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  // count register with synchronous active-low reset
  always_ff @(posedge clk)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/seq_det_param.sv
// seq_det_param: Moore serial pattern detector with runtime pattern, overlap mode and match counter
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN_1101),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in,
  input  logic             in_valid,
  input  logic             ovl_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);
  localparam int FW = fill_w(PAT_W);
  logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d, nxt;
  logic [FW-1:0]    fill_q, fill_d;
  logic             out_q, accept, hit;
  // shift/compare: a hit needs a full window of accepted bits; pattern load flushes history
  always_comb begin
    nxt    = {hist_q[PAT_W-2:0], in};
    accept = in_valid && !pat_load;
    hit    = accept && (nxt == pat_q) && (fill_q >= FW'(PAT_W - 1));
    hist_d = pat_load ? '0 : accept ? nxt : hist_q;
    fill_d = pat_load ? '0 :
             !accept ? fill_q :
             (hit && !ovl_en) ? '0 :
             (fill_q == FW'(PAT_W)) ? fill_q : fill_q + FW'(1);
    pat_d  = pat_load ? pat_in : pat_q;
  end
  // state and registered match pulse
  always_ff @(posedge clk)
    if (!rstn) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      out_q  <= hit;
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rstn(rstn),
    .clr (cnt_clr),
    .inc (hit),
    .q   (match_cnt)
  );
  assign out  = out_q;
  assign busy = (fill_q != '0);
endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: vector table plus hand-written saturation sequence, scoreboarded
module tb_seq_det_param;
  typedef struct {
    logic       rstn, iv, d, ovl, pl;
    logic [3:0] pi;
    logic       clr, eo;
    int         ec;
    logic       eb;
  } vec_t;

  logic clk = 1'b0, rstn, din, in_valid, ovl_en, pat_load, cnt_clr;
  logic [3:0] pat_in;
  logic out, busy, out2, busy2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  int total = 0, bad = 0, vid = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  seq_det_param dut (
    .clk(clk), .rstn(rstn), .in(din), .in_valid(in_valid), .ovl_en(ovl_en),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .out(out), .match_cnt(match_cnt), .busy(busy)
  );

  seq_det_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .in(din), .in_valid(in_valid), .ovl_en(ovl_en),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .out(out2), .match_cnt(match_cnt2), .busy(busy2)
  );

  task automatic a(input logic r, iv, d, ovl, pl, input logic [3:0] pi,
                   input logic clr, eo, input int ec, input logic eb);
    vec_t v;
    v.rstn = r; v.iv = iv; v.d = d; v.ovl = ovl; v.pl = pl; v.pi = pi;
    v.clr = clr; v.eo = eo; v.ec = ec; v.eb = eb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL v%0d %s: got %0d expected %0d", vid, nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rstn = v.rstn; in_valid = v.iv; din = v.d; ovl_en = v.ovl;
    pat_load = v.pl; pat_in = v.pi; cnt_clr = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL v%0d scoreboard: got empty queue expected an entry", vid);
    end else begin
      e = sb.pop_front();
      chk("out", int'(out), int'(e.eo));
      chk("match_cnt", int'(match_cnt), e.ec);
      chk("busy", int'(busy), int'(e.eb));
      chk("match_cnt_w2", int'(match_cnt2), e.ec > 3 ? 3 : e.ec);
    end
    vid++;
  endtask

  initial begin
    vec_t v;
    rstn = 1'b0; din = 1'b0; in_valid = 1'b0; ovl_en = 1'b0;
    pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
    // overlapping stream 1101101
    a(0,0,0,1,0,0,0, 0,0,0); a(0,0,0,1,0,0,0, 0,0,0);
    a(1,1,1,1,0,0,0, 0,0,1); a(1,1,1,1,0,0,0, 0,0,1);
    a(1,1,0,1,0,0,0, 0,0,1); a(1,1,1,1,0,0,0, 1,1,1);
    a(1,1,1,1,0,0,0, 0,1,1); a(1,1,0,1,0,0,0, 0,1,1);
    a(1,1,1,1,0,0,0, 1,2,1);
    // non-overlapping: history discarded after the match
    a(0,0,0,0,0,0,0, 0,0,0);
    a(1,1,1,0,0,0,0, 0,0,1); a(1,1,1,0,0,0,0, 0,0,1);
    a(1,1,0,0,0,0,0, 0,0,1); a(1,1,1,0,0,0,0, 1,1,0);
    a(1,1,1,0,0,0,0, 0,1,1); a(1,1,0,0,0,0,0, 0,1,1);
    a(1,1,1,0,0,0,0, 0,1,1);
    // valid gap keeps partial match
    a(0,0,0,1,0,0,0, 0,0,0);
    a(1,1,1,1,0,0,0, 0,0,1); a(1,1,1,1,0,0,0, 0,0,1);
    a(1,1,0,1,0,0,0, 0,0,1);
    for (int i = 0; i < 5; i++) a(1,0,i[0],1,0,0,0, 0,0,1);
    a(1,1,1,1,0,0,0, 1,1,1);
    // reset mid-sequence discards history, even with a valid bit on the reset edge
    a(0,0,0,1,0,0,0, 0,0,0);
    a(1,1,1,1,0,0,0, 0,0,1); a(1,1,1,1,0,0,0, 0,0,1);
    a(1,1,0,1,0,0,0, 0,0,1);
    a(0,1,1,1,0,0,0, 0,0,0);
    a(1,1,1,1,0,0,0, 0,0,1);
    // runtime pattern load beats a concurrent sample
    a(0,0,0,0,0,0,0, 0,0,0);
    a(1,1,1,0,1,4'b0110,0, 0,0,0);
    a(1,1,0,0,0,0,0, 0,0,1); a(1,1,1,0,0,0,0, 0,0,1);
    a(1,1,1,0,0,0,0, 0,0,1); a(1,1,0,0,0,0,0, 1,1,0);
    a(1,1,1,0,0,0,0, 0,1,1); a(1,1,1,0,0,0,0, 0,1,1);
    a(1,1,0,0,0,0,0, 0,1,1); a(1,1,1,0,0,0,0, 0,1,1);
    a(1,0,0,0,1,4'b1101,0, 0,1,0);
    a(1,0,0,1,0,0,1, 0,0,0);
    foreach (tbl[i]) step(tbl[i]);
    // saturation: 1101 x5 overlapping; 2-bit counter sticks at 3, 8-bit reaches 5
    for (int r = 0; r < 5; r++)
      for (int b = 0; b < 4; b++) begin
        v.rstn = 1; v.iv = 1; v.ovl = 1; v.pl = 0; v.pi = 0; v.clr = 0; v.eb = 1;
        v.d = (b != 2);
        v.eo = (b == 3);
        v.ec = (b == 3) ? r + 1 : r;
        step(v);
      end
    // clear coincident with a hit: counters zero, pulse still fires
    v.rstn = 1; v.iv = 1; v.ovl = 1; v.pl = 0; v.pi = 0; v.clr = 0; v.eb = 1;
    v.eo = 0; v.ec = 5;
    v.d = 1; step(v);
    v.d = 1; step(v);
    v.d = 0; step(v);
    v.d = 1; v.clr = 1; v.eo = 1; v.ec = 0; step(v);
    v.iv = 0; v.clr = 0; v.eo = 0; step(v);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
